// File: rtl/ssb_sync_pkg.sv
// Shared types and constants for the SSB sync controller and its SSS bit gate.
package ssb_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        TRACK   = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        XFER = 2'd2,
        WAIT = 2'd3
    } sss_state_t;

    localparam logic [1:0] PSS_MODE_SEARCH = 2'd0;
    localparam logic [1:0] PSS_MODE_TRACK  = 2'd1;

    localparam int N_ID_1_W = 9;
    localparam int N_ID_W   = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sss_bit_gate.sv
// SSS sub-FSM: skips the leading subcarriers, forwards the SSS bits, then waits
// for the SSS detector result or gives up after a timeout.
module sss_bit_gate
    import ssb_sync_pkg::*;
#(
    parameter int SSS_START   = 63,
    parameter int SSS_LEN     = 127,
    parameter int SSS_TIMEOUT = 4096
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic                sc_tdata_i,
    input  logic                sc_tvalid_i,
    input  logic [N_ID_1_W-1:0] n_id_1_i,
    input  logic                n_id_1_valid_i,
    output logic                bit_tdata_o,
    output logic                bit_tvalid_o,
    output logic [N_ID_1_W-1:0] n_id_1_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int CW = $clog2(max3(SSS_START, SSS_LEN, SSS_TIMEOUT) + 1);
    localparam logic [CW-1:0] START_LAST = CW'(SSS_START - 1);
    localparam logic [CW-1:0] LEN_LAST   = CW'(SSS_LEN - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(SSS_TIMEOUT - 1);

    sss_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bit_q, bit_d;
    logic                vld_q, vld_d;
    logic [N_ID_1_W-1:0] nid1_q, nid1_d;
    logic                done_q, done_d;
    logic                tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        vld_d   = 1'b0;
        nid1_d  = nid1_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if (arm_i) begin
                cnt_d   = '0;
                state_d = SKIP;
            end
            SKIP: if (sc_tvalid_i) begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            XFER: if (sc_tvalid_i) begin
                vld_d = 1'b1;
                bit_d = sc_tdata_i;
                if (cnt_q == LEN_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (n_id_1_valid_i) begin
                    nid1_d  = n_id_1_i;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Lock loss kills any in-flight transfer; no bit strobe may follow it.
        if (abort_i) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            vld_q   <= 1'b0;
            nid1_q  <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            vld_q   <= vld_d;
            nid1_q  <= nid1_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bit_tdata_o  = bit_q;
    assign bit_tvalid_o = vld_q;
    assign n_id_1_o     = nid1_q;
    assign done_o       = done_q;
    assign timeout_o    = tmo_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/ssb_sync_ctrl.sv
// Cell acquisition sequencer: PSS search -> confirm -> track, with one SSS
// attempt per lock. Optional SSB_SYNC_CTRL_STATS_EN adds lock-loss/timeout counters.
module ssb_sync_ctrl
    import ssb_sync_pkg::*;
#(
    parameter int SSB_PERIOD_CYCLES = 76800,
    parameter int WINDOW_HALF       = 64,
    parameter int CONFIRM_CNT       = 2,
    parameter int LOSS_CNT          = 3,
    parameter int SSS_START         = 63,
    parameter int SSS_LEN           = 127,
    parameter int SSS_TIMEOUT       = 4096
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [1:0]          N_id_2_i,
    input  logic                N_id_2_valid_i,
    output logic [1:0]          PSS_detector_mode_o,
    output logic [1:0]          requested_N_id_2_o,
    input  logic                SSS_sc_tdata_i,
    input  logic                SSS_sc_tvalid_i,
    output logic                m_axis_SSS_bit_tdata,
    output logic                m_axis_SSS_bit_tvalid,
    input  logic [N_ID_1_W-1:0] N_id_1_i,
    input  logic                N_id_1_valid_i,
    output logic [N_ID_W-1:0]   N_id_o,
    output logic                N_id_valid_o,
    output logic                locked_o,
    output logic [2:0]          state_debug_o
`ifdef SSB_SYNC_CTRL_STATS_EN
    ,
    output logic [15:0]         lock_loss_cnt_o,
    output logic [15:0]         sss_timeout_cnt_o
`endif
);

    localparam int TW = $clog2(SSB_PERIOD_CYCLES + WINDOW_HALF + 1);
    localparam int HW = $clog2(CONFIRM_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [TW-1:0] WIN_LO = TW'(SSB_PERIOD_CYCLES - WINDOW_HALF);
    localparam logic [TW-1:0] WIN_HI = TW'(SSB_PERIOD_CYCLES + WINDOW_HALF);
    localparam logic [TW-1:0] PERIOD = TW'(SSB_PERIOD_CYCLES);

    main_state_t       state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [HW-1:0]     hits_q, hits_d;
    logic [MW-1:0]     misses_q, misses_d;
    logic [1:0]        nid2_q, nid2_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        req_q, req_d;
    logic              locked_q, locked_d;
    logic [N_ID_W-1:0] nid_q, nid_d;
    logic              nid_valid_q, nid_valid_d;
    logic              nid_known_q, nid_known_d;
    logic              in_win, hit, expire, arm, abort, lost;

    logic                sss_done, sss_tmo, sss_busy;
    logic [N_ID_1_W-1:0] sss_nid1;

    always_comb begin
        in_win = (timer_q >= WIN_LO) && (timer_q <= WIN_HI);
        hit    = N_id_2_valid_i && in_win && (N_id_2_i == nid2_q);
        expire = (timer_q == WIN_HI) && !hit;

        state_d     = state_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        nid2_d      = nid2_q;
        nid_d       = nid_q;
        nid_valid_d = 1'b0;
        nid_known_d = nid_known_q;
        arm         = 1'b0;
        abort       = 1'b0;
        lost        = 1'b0;
        // Timer reads the number of cycles since the reference peak; a hit
        // reloads 1 because the next cycle is already one cycle past the peak.
        timer_d     = (state_q == SEARCH) ? '0 : timer_q + TW'(1);

        case (state_q)
            SEARCH: if (N_id_2_valid_i) begin
                nid2_d  = N_id_2_i;
                timer_d = TW'(1);
                hits_d  = HW'(1);
                state_d = CONFIRM;
            end
            CONFIRM: begin
                if (hit) begin
                    timer_d = TW'(1);
                    if (int'(hits_q) + 1 >= CONFIRM_CNT) begin
                        state_d  = TRACK;
                        misses_d = '0;
                        arm      = 1'b1;
                    end else begin
                        hits_d = hits_q + HW'(1);
                    end
                end else if (expire) begin
                    state_d = SEARCH;
                end
            end
            TRACK: begin
                if (sss_done) begin
                    nid_d       = N_ID_W'(sss_nid1) * N_ID_W'(3) + N_ID_W'(nid2_q);
                    nid_valid_d = 1'b1;
                    nid_known_d = 1'b1;
                end
                if (hit) begin
                    misses_d = '0;
                    timer_d  = TW'(1);
                    arm      = !nid_known_q;
                end else if (expire) begin
                    if (int'(misses_q) + 1 >= LOSS_CNT) begin
                        state_d     = SEARCH;
                        timer_d     = '0;
                        misses_d    = '0;
                        nid_d       = '0;
                        nid_valid_d = 1'b0;
                        nid_known_d = 1'b0;
                        abort       = 1'b1;
                        lost        = 1'b1;
                    end else begin
                        misses_d = misses_q + MW'(1);
                        timer_d  = timer_q - PERIOD + TW'(1);
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        mode_d   = (state_d == SEARCH) ? PSS_MODE_SEARCH : PSS_MODE_TRACK;
        req_d    = nid2_d;
        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= SEARCH;
            timer_q     <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            nid2_q      <= '0;
            mode_q      <= PSS_MODE_SEARCH;
            req_q       <= '0;
            locked_q    <= 1'b0;
            nid_q       <= '0;
            nid_valid_q <= 1'b0;
            nid_known_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            nid2_q      <= nid2_d;
            mode_q      <= mode_d;
            req_q       <= req_d;
            locked_q    <= locked_d;
            nid_q       <= nid_d;
            nid_valid_q <= nid_valid_d;
            nid_known_q <= nid_known_d;
        end
    end

    sss_bit_gate #(
        .SSS_START  (SSS_START),
        .SSS_LEN    (SSS_LEN),
        .SSS_TIMEOUT(SSS_TIMEOUT)
    ) u_gate (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .arm_i         (arm),
        .abort_i       (abort),
        .sc_tdata_i    (SSS_sc_tdata_i),
        .sc_tvalid_i   (SSS_sc_tvalid_i),
        .n_id_1_i      (N_id_1_i),
        .n_id_1_valid_i(N_id_1_valid_i),
        .bit_tdata_o   (m_axis_SSS_bit_tdata),
        .bit_tvalid_o  (m_axis_SSS_bit_tvalid),
        .n_id_1_o      (sss_nid1),
        .done_o        (sss_done),
        .timeout_o     (sss_tmo),
        .busy_o        (sss_busy)
    );

    assign PSS_detector_mode_o = mode_q;
    assign requested_N_id_2_o  = req_q;
    assign N_id_o              = nid_q;
    assign N_id_valid_o        = nid_valid_q;
    assign locked_o            = locked_q;
    assign state_debug_o       = {sss_busy, state_q};

`ifdef SSB_SYNC_CTRL_STATS_EN
    logic [15:0] lock_loss_q, lock_loss_d;
    logic [15:0] sss_tmo_cnt_q, sss_tmo_cnt_d;

    always_comb begin
        lock_loss_d   = lock_loss_q;
        sss_tmo_cnt_d = sss_tmo_cnt_q;
        if (lost && lock_loss_q != 16'hFFFF) lock_loss_d = lock_loss_q + 16'd1;
        if (sss_tmo && sss_tmo_cnt_q != 16'hFFFF) sss_tmo_cnt_d = sss_tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lock_loss_q   <= '0;
            sss_tmo_cnt_q <= '0;
        end else begin
            lock_loss_q   <= lock_loss_d;
            sss_tmo_cnt_q <= sss_tmo_cnt_d;
        end
    end

    assign lock_loss_cnt_o   = lock_loss_q;
    assign sss_timeout_cnt_o = sss_tmo_cnt_q;
`else
    logic sss_tmo_unused;
    assign sss_tmo_unused = sss_tmo;
`endif

endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// Directed/randomized bench for ssb_sync_ctrl: acquisition, window edges, SSS
// gating, lock loss, SSS timeout and async reset.
module tb_ssb_sync_ctrl;

    localparam int P = 1000, W = 4, TMO = 200, START = 63, LEN = 127;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic [1:0] N_id_2_i = '0;
    logic       N_id_2_valid_i = 1'b0;
    logic [1:0] PSS_detector_mode_o, requested_N_id_2_o;
    logic       SSS_sc_tdata_i = 1'b0, SSS_sc_tvalid_i = 1'b0;
    logic       m_axis_SSS_bit_tdata, m_axis_SSS_bit_tvalid;
    logic [8:0] N_id_1_i = '0;
    logic       N_id_1_valid_i = 1'b0;
    logic [9:0] N_id_o;
    logic       N_id_valid_o, locked_o;
    logic [2:0] state_debug_o;
`ifdef SSB_SYNC_CTRL_STATS_EN
    logic [15:0] lock_loss_cnt_o, sss_timeout_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    ssb_sync_ctrl #(
        .SSB_PERIOD_CYCLES(P), .WINDOW_HALF(W), .CONFIRM_CNT(2), .LOSS_CNT(3),
        .SSS_START(START), .SSS_LEN(LEN), .SSS_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .N_id_2_i(N_id_2_i), .N_id_2_valid_i(N_id_2_valid_i),
        .PSS_detector_mode_o(PSS_detector_mode_o), .requested_N_id_2_o(requested_N_id_2_o),
        .SSS_sc_tdata_i(SSS_sc_tdata_i), .SSS_sc_tvalid_i(SSS_sc_tvalid_i),
        .m_axis_SSS_bit_tdata(m_axis_SSS_bit_tdata), .m_axis_SSS_bit_tvalid(m_axis_SSS_bit_tvalid),
        .N_id_1_i(N_id_1_i), .N_id_1_valid_i(N_id_1_valid_i),
        .N_id_o(N_id_o), .N_id_valid_o(N_id_valid_o), .locked_o(locked_o),
        .state_debug_o(state_debug_o)
`ifdef SSB_SYNC_CTRL_STATS_EN
        , .lock_loss_cnt_o(lock_loss_cnt_o), .sss_timeout_cnt_o(sss_timeout_cnt_o)
`endif
    );

    int cyc = 0;
    int nid_pulses = 0;
    int checks = 0, errors = 0;
    bit got[$];
    bit expq[$];

    always @(posedge clk_i) begin
        cyc++;
        if (m_axis_SSS_bit_tvalid) got.push_back(m_axis_SSS_bit_tdata);
        if (N_id_valid_o) nid_pulses++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Return just after edge t has been sampled.
    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    // Peak strobe sampled at edge t.
    task automatic peak(input int t, input logic [1:0] id);
        wait_to(t - 1);
        N_id_2_i = id;
        N_id_2_valid_i = 1'b1;
        tick();
        N_id_2_valid_i = 1'b0;
    endtask

    // Strobes with attempt-relative indices [i0,i1); model: index START..START+LEN-1 forwarded.
    task automatic strobes(input int i0, input int i1, input int gmax, input bit alt);
        for (int k = i0; k < i1; k++) begin
            bit d;
            d = alt ? k[0] : 1'($urandom_range(0, 1));
            if (k >= START && k < START + LEN) expq.push_back(d);
            repeat ($urandom_range(0, gmax)) tick();
            SSS_sc_tdata_i = d;
            SSS_sc_tvalid_i = 1'b1;
            tick();
            SSS_sc_tvalid_i = 1'b0;
        end
    endtask

    task automatic check_bits(input string tag, input int base);
        int mism;
        mism = 0;
        chk({tag, "_cnt"}, got.size() - base, expq.size());
        for (int j = 0; j < expq.size(); j++)
            if (got.size() <= base + j || got[base + j] !== expq[j]) mism++;
        chk({tag, "_bits"}, mism, 0);
    endtask

    task automatic wait_nid(input string tag, input int exp_nid);
        for (int n = 0; n < 20 && !N_id_valid_o; n++) tick();
        chk({tag, "_pulse"}, N_id_valid_o, 1);
        chk({tag, "_val"}, N_id_o, exp_nid);
        tick();
        chk({tag, "_pulse_end"}, N_id_valid_o, 0);
        chk({tag, "_hold"}, N_id_o, exp_nid);
    endtask

    initial begin
        int base, last_hit, t0, t1, e, np, n1;
        logic [1:0] c;

        // Reset
        repeat (3) tick();
        chk("rst_mode", PSS_detector_mode_o, 0);
        chk("rst_req", requested_N_id_2_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_nid", N_id_o, 0);
        chk("rst_tvalid", m_axis_SSS_bit_tvalid, 0);
        chk("rst_dbg", state_debug_o, 0);
        reset_ni = 1'b1;

        // Acquire N_id_2=2 with peaks at cycles 100 and 1100
        wait_to(99);
        chk("acq_pre_mode", PSS_detector_mode_o, 0);
        peak(100, 2'd2);
        chk("acq_mode", PSS_detector_mode_o, 1);
        chk("acq_req", requested_N_id_2_o, 2);
        chk("acq_not_locked", locked_o, 0);
        chk("acq_dbg_confirm", state_debug_o, 3'b001);
        peak(1100, 2'd2);
        last_hit = 1100;
        chk("acq_locked", locked_o, 1);
        chk("acq_dbg_track_armed", state_debug_o, 3'b110);

        // SSS transfer with bit = index[0]
        expq.delete();
        base = got.size();
        strobes(0, 200, 2, 1'b1);
        repeat (3) tick();
        check_bits("sss1", base);
        chk("sss1_first", (got.size() > base) ? 32'(got[base]) : 32'd9, 1);
        chk("sss1_dbg_wait", state_debug_o, 3'b110);
        np = nid_pulses;
        N_id_1_i = 9'd100;
        N_id_1_valid_i = 1'b1;
        tick();
        N_id_1_valid_i = 1'b0;
        wait_nid("nid1", 302);
        chk("nid1_idle", state_debug_o, 3'b010);
        N_id_1_i = 9'd55;
        N_id_1_valid_i = 1'b1;
        tick();
        N_id_1_valid_i = 1'b0;
        repeat (3) tick();
        chk("nid1_ignored_val", N_id_o, 302);
        chk("nid1_pulse_count", nid_pulses - np, 1);

        // Tracking hit somewhere in the window, no re-arm once N_id known
        t0 = last_hit + P - W + $urandom_range(0, 2 * W);
        peak(t0, 2'd2);
        last_hit = t0;
        chk("trk_hit_locked", locked_o, 1);
        chk("trk_no_rearm", state_debug_o, 3'b010);

        // Lock loss after three expiries with freewheel
        wait_to(last_hit + P + W);
        chk("loss_miss1", locked_o, 1);
        wait_to(last_hit + 2 * P + W);
        chk("loss_miss2", locked_o, 1);
        wait_to(last_hit + 3 * P + W - 1);
        chk("loss_pre", locked_o, 1);
        chk("loss_pre_nid", N_id_o, 302);
        wait_to(last_hit + 3 * P + W);
        chk("loss_locked", locked_o, 0);
        chk("loss_nid", N_id_o, 0);
        chk("loss_mode", PSS_detector_mode_o, 0);
        chk("loss_dbg", state_debug_o, 0);

        // Low window edge hit, then abort in the middle of a transfer
        c = 2'($urandom_range(0, 2));
        t0 = cyc + 20;
        peak(t0, c);
        t1 = t0 + P - W;
        peak(t1, c);
        chk("win_lo_edge_hit", locked_o, 1);
        expq.delete();
        wait_to(t1 + 3 * P + W - 81);
        base = got.size();
        for (int k = 0; k < 91; k++) begin
            bit d;
            d = 1'($urandom_range(0, 1));
            if (k >= START && k < 80) expq.push_back(d);
            SSS_sc_tdata_i = d;
            SSS_sc_tvalid_i = 1'b1;
            tick();
            if (cyc == t1 + 3 * P + W) begin
                chk("abort_tvalid", m_axis_SSS_bit_tvalid, 0);
                chk("abort_unlocked", locked_o, 0);
            end
        end
        SSS_sc_tvalid_i = 1'b0;
        repeat (2) tick();
        check_bits("abort", base);

        // Just outside the window and wrong-id peaks are ignored; expiry -> SEARCH
        c = 2'($urandom_range(0, 2));
        t0 = cyc + 20;
        peak(t0, c);
        peak(t0 + P - W - 1, c);
        chk("win_out_mode", PSS_detector_mode_o, 1);
        chk("win_out_unlocked", locked_o, 0);
        peak(t0 + P, 2'((c + 2'd1) % 3));
        chk("wrong_id_unlocked", locked_o, 0);
        wait_to(t0 + P + W - 1);
        chk("exp_pre_mode", PSS_detector_mode_o, 1);
        wait_to(t0 + P + W);
        chk("exp_mode", PSS_detector_mode_o, 0);
        chk("exp_dbg", state_debug_o, 0);

        // SSS timeout, then re-arm on the next hit
        c = 2'($urandom_range(0, 2));
        t0 = cyc + 20;
        peak(t0, c);
        peak(t0 + P, c);
        last_hit = t0 + P;
        chk("tmo_locked", locked_o, 1);
        expq.delete();
        base = got.size();
        strobes(0, START + LEN, 1, 1'b0);
        e = cyc;
        strobes(START + LEN, 200, 1, 1'b0);
        wait_to(e + TMO - 1);
        chk("tmo_still_wait", state_debug_o, 3'b110);
        wait_to(e + TMO);
        chk("tmo_idle", state_debug_o, 3'b010);
        check_bits("tmo_sss", base);
        tick();
`ifdef SSB_SYNC_CTRL_STATS_EN
        chk("stat_tmo", sss_timeout_cnt_o, 1);
        chk("stat_loss", lock_loss_cnt_o, 2);
`endif
        t0 = last_hit + P - W + $urandom_range(0, 2 * W);
        peak(t0, c);
        chk("rearm_dbg", state_debug_o, 3'b110);
        expq.delete();
        base = got.size();
        strobes(0, 200, 1, 1'b0);
        repeat (2) tick();
        check_bits("rearm_sss", base);
        n1 = $urandom_range(0, 335);
        N_id_1_i = 9'(n1);
        N_id_1_valid_i = 1'b1;
        tick();
        N_id_1_valid_i = 1'b0;
        wait_nid("nid2", 3 * n1 + int'(c));
        chk("nid_pulse_total", nid_pulses, 2);

        // Async reset asserted mid-transfer
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        tick();
        t0 = cyc + 10;
        peak(t0, c);
        peak(t0 + P, c);
        chk("ar_locked", locked_o, 1);
        expq.delete();
        strobes(0, 80, 0, 1'b0);
        chk("ar_xfer_active", m_axis_SSS_bit_tvalid, 1);
        SSS_sc_tvalid_i = 1'b1;
        #2;
        reset_ni = 1'b0;
        #1;
        chk("ar_tvalid", m_axis_SSS_bit_tvalid, 0);
        chk("ar_tdata", m_axis_SSS_bit_tdata, 0);
        chk("ar_mode", PSS_detector_mode_o, 0);
        chk("ar_req", requested_N_id_2_o, 0);
        chk("ar_locked0", locked_o, 0);
        chk("ar_nid", N_id_o, 0);
        chk("ar_nid_valid", N_id_valid_o, 0);
        chk("ar_dbg", state_debug_o, 0);
        base = got.size();
        repeat (3) tick();
        reset_ni = 1'b1;
        repeat (6) tick();
        SSS_sc_tvalid_i = 1'b0;
        tick();
        chk("ar_no_tvalid_after", got.size() - base, 0);
        chk("ar_still_search", state_debug_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssb_sync_ctrl.md
Name: ssb_sync_ctrl

Overview:
Controller that sequences cell acquisition around the PSS detector, FFT demodulator and SSS detector. It drives the PSS detector from blind search into tracking of one N_id_2. Lock is confirmed from periodic peaks, and lock is dropped after repeated missed peaks. Once per lock it gates the 127 SSS subcarrier bits into the SSS detector and combines the result into N_id. It sits between PSS_detector/FFT_demod and SSS_detector in the receiver top level.

Parameters:
SSB_PERIOD_CYCLES, 76800, expected clk_i cycles between PSS peaks (20 ms SSB period)
WINDOW_HALF, 64, accepted peak deviation from the expected time, +/- cycles
CONFIRM_CNT, 2, consecutive in-window peaks needed to declare lock (first peak counts as 1)
LOSS_CNT, 3, consecutive missed windows that drop lock
SSS_START, 63, SSS-symbol subcarrier strobes discarded before the SSS bits
SSS_LEN, 127, SSS bits forwarded per attempt
SSS_TIMEOUT, 4096, cycles to wait for the SSS detector result

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
N_id_2_i  in  2  N_id_2 of the current PSS peak
N_id_2_valid_i  in  1  one-cycle PSS peak strobe
PSS_detector_mode_o  out  2  0 = search all N_id_2, 1 = track requested_N_id_2_o
requested_N_id_2_o  out  2  N_id_2 to track
SSS_sc_tdata_i  in  1  demodulated SSS-symbol subcarrier bit (inverted real-part MSB)
SSS_sc_tvalid_i  in  1  subcarrier strobe from FFT_demod (SSS_valid_o)
m_axis_SSS_bit_tdata  out  1  bit to SSS detector
m_axis_SSS_bit_tvalid  out  1  bit strobe to SSS detector
N_id_1_i  in  9  SSS detector result
N_id_1_valid_i  in  1  result strobe
N_id_o  out  10  3*N_id_1 + N_id_2, held while locked
N_id_valid_o  out  1  one-cycle pulse when N_id_o updates
locked_o  out  1  high in TRACK
state_debug_o  out  3  {sss_busy, main_state[1:0]}

Behaviour:
- Reset: every output 0; main state SEARCH; SSS sub-FSM IDLE; timer, hit and miss counters 0. Reset is asynchronous and active-low.
- Timer: unsigned, width $clog2(SSB_PERIOD_CYCLES+WINDOW_HALF+1). It increments every cycle outside SEARCH.
- In-window test: SSB_PERIOD_CYCLES-WINDOW_HALF <= timer <= SSB_PERIOD_CYCLES+WINDOW_HALF. Both edges count as in-window.
- Expiry: timer == SSB_PERIOD_CYCLES+WINDOW_HALF with no hit in the current window.
- SEARCH: mode 0. On N_id_2_valid_i, latch N_id_2, set timer=0 and hits=1, go to CONFIRM. Mode and requested outputs are registered, so they change the next cycle.
- CONFIRM: mode 1.
  - An in-window peak whose N_id_2 matches the latch: hits+1, timer=0. If hits reaches CONFIRM_CNT, go to TRACK and arm the SSS sub-FSM.
  - A mismatched or out-of-window peak is ignored.
  - Expiry returns to SEARCH.
- TRACK: locked_o=1.
  - Hit: misses=0, timer=0.
  - Expiry: misses+1, timer=timer-SSB_PERIOD_CYCLES (freewheel). If misses reaches LOSS_CNT, go to SEARCH, clear locked_o and N_id_o, and abort the SSS sub-FSM to IDLE.
- Peak and expiry in the same cycle: the hit wins.
- SSS sub-FSM states are IDLE, SKIP, XFER, WAIT. It runs only in TRACK.
  - IDLE: on arm, clear the strobe counter and go to SKIP.
  - SKIP: count SSS_sc_tvalid_i strobes. On the SSS_START-th strobe (counter==SSS_START-1), go to XFER. Strobes 0..62 are discarded.
  - XFER: forward each strobe to m_axis_SSS_bit_* with one registered cycle of latency. After exactly SSS_LEN bits (strobes 63..189), go to WAIT. Strobes arriving in WAIT are not forwarded.
  - WAIT: on N_id_1_valid_i, set N_id_o = 3*N_id_1_i + latched N_id_2 (10-bit), pulse N_id_valid_o for one cycle, go to IDLE with the nid_known flag set.
  - Timeout (SSS_TIMEOUT cycles in WAIT): go to IDLE and re-arm on the next TRACK hit.
  - N_id_1_valid_i outside WAIT is ignored.
  - With nid_known set, later hits do not arm. The flag clears on lock loss.
- Reset asserted mid-transfer: outputs clear immediately, with no partial tvalid after release.

Optional Feature:
SSB_SYNC_CTRL_STATS_EN: when defined, adds outputs lock_loss_cnt_o [15:0] and sss_timeout_cnt_o [15:0]. Both are saturating counters, incremented on TRACK->SEARCH and on SSS timeout respectively, and reset to 0. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package ssb_sync_pkg holds:
  - main_state_t {SEARCH, CONFIRM, TRACK};
  - sss_state_t {IDLE, SKIP, XFER, WAIT};
  - PSS_MODE_SEARCH=2'd0, PSS_MODE_TRACK=2'd1;
  - N_ID_1_W=9, N_ID_W=10.
- Sub-module sss_bit_gate implements the SSS sub-FSM (arm/abort in; bit strobe, N_id_1 capture and timeout out).

Test Plan:
Bench parameters: SSB_PERIOD_CYCLES=1000, WINDOW_HALF=4, CONFIRM_CNT=2, LOSS_CNT=3, SSS_TIMEOUT=200.
- Acquire: peak N_id_2=2 at cycle 100, peak at 1100 -> mode 1 / requested 2 from cycle 101; locked_o=1 from cycle 1101.
- Window edges: after the first peak at t0, peak at t0+996 -> hit. Separate run: peak at t0+995 ignored, expiry at t0+1004 -> SEARCH, mode 0.
- SSS: in TRACK, 200 strobes with bit=i[0] -> exactly 127 tvalid, first bit = strobe 63 value (1). N_id_1_i=100 -> N_id_o=302 with a one-cycle N_id_valid_o.
- Loss: lock, then no peaks -> misses at 3 expiries, locked_o=0 and N_id_o=0 after the third expiry. Aborting during XFER stops tvalid immediately.
- Timeout: no N_id_1_valid_i for 200 cycles in WAIT -> IDLE. The next hit re-arms and 127 bits are forwarded again; stats counter =1 when SSB_SYNC_CTRL_STATS_EN is defined.
- Async reset asserted mid-XFER -> all outputs 0 without a clock edge; state_debug_o=0.
